// File: rtl/fmlmem_pkg.sv
// fmlmem_pkg: shared constants for the FML block-RAM slave.
//   FSM state encodings, burst geometry and beat/byte-enable widths.
package fmlmem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;
  localparam logic [1:0] ST_BURST = 2'd3;

  localparam int unsigned BURST_LEN  = 4;
  localparam int unsigned BEAT_W     = 64;
  localparam int unsigned BEAT_CNT_W = 2;
  localparam int unsigned SEL_W      = BEAT_W / 8;

  typedef logic [BEAT_W-1:0] beat_t;

endpackage

// File: rtl/fmlmem_if.sv
// fmlmem_if: FML burst bus bundle.
//   fml_adr  burst byte address (master -> slave)
//   fml_stb  request strobe     (master -> slave)
//   fml_we   write burst flag   (master -> slave)
//   fml_sel  byte enables       (master -> slave)
//   fml_di   write data         (master -> slave)
//   fml_ack  acknowledge        (slave -> master)
//   fml_do   read data          (slave -> master)
interface fmlmem_if #(
  parameter int fml_depth = 26
);
  import fmlmem_pkg::*;

  logic [fml_depth-1:0] fml_adr;
  logic                 fml_stb;
  logic                 fml_we;
  logic [SEL_W-1:0]     fml_sel;
  beat_t                fml_di;
  logic                 fml_ack;
  beat_t                fml_do;

  modport master (
    output fml_adr, fml_stb, fml_we, fml_sel, fml_di,
    input  fml_ack, fml_do
  );

  modport slave (
    input  fml_adr, fml_stb, fml_we, fml_sel, fml_di,
    output fml_ack, fml_do
  );

endinterface

// File: rtl/fmlmem_ram.sv
// fmlmem_ram: single-port 64-bit RAM with per-byte write enables and
// synchronous (read-before-write) output; maps onto block RAM.
//   clk  clock
//   we   write enable
//   sel  byte enables, bit 7 = [63:56]
//   adr  word address
//   di   write data
//   dq   registered read data of the address presented last cycle
module fmlmem_ram
  import fmlmem_pkg::*;
#(
  parameter int addr_w = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [SEL_W-1:0]  sel,
  input  logic [addr_w-1:0] adr,
  input  beat_t             di,
  output beat_t             dq
);

  beat_t mem [2**addr_w];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < SEL_W; i++) begin
        if (sel[i]) mem[adr][i*8 +: 8] <= di[i*8 +: 8];
      end
    end
    dq <= mem[adr];
  end

endmodule

// File: rtl/fmlmem.sv
// fmlmem: FML slave answering 4x64-bit bursts from on-chip byte-writable RAM,
// with a configurable request-to-ack latency.
//   sys_clk  clock, rising edge
//   sys_rst  synchronous active-high reset
//   fml      FML slave bus (fmlmem_if.slave)
module fmlmem
  import fmlmem_pkg::*;
#(
  parameter int fml_depth   = 26,
  parameter int mem_depth   = 14,
  parameter int ack_latency = 2
) (
  input  logic     sys_clk,
  input  logic     sys_rst,
  fmlmem_if.slave  fml
);

  localparam int LINE_W = mem_depth - 5;
  localparam int RAM_AW = mem_depth - 3;
  localparam logic [3:0] LAT_LOAD = 4'(ack_latency - 1);

  logic [1:0]            state;
  logic [3:0]            lat_cnt;
  logic [BEAT_CNT_W-1:0] beat;
  logic [LINE_W-1:0]     line_q;
  logic                  we_q;
  beat_t                 do_hold;

  logic                  in_burst;
  logic                  ram_we;
  logic [RAM_AW-1:0]     ram_adr;
  beat_t                 ram_q;

  assign in_burst = (state == ST_ACK) || (state == ST_BURST);
  // Reset wins over a write beat in the same cycle so a burst cut by reset
  // leaves its remaining beats untouched.
  assign ram_we   = in_burst && we_q && !sys_rst;
  assign fml.fml_ack = (state == ST_ACK);
  // Read beats come straight from the RAM; outside read bursts the last beat
  // is held.
  assign fml.fml_do  = (in_burst && !we_q) ? ram_q : do_hold;

  // Single port: writes use the current beat's address, reads run one beat
  // ahead to hide the synchronous read. IDLE prefetches beat 0 from the live
  // address so a latency of 1 still has data ready in the ack cycle.
  always_comb begin
    ram_adr = {line_q, beat};
    case (state)
      ST_IDLE: ram_adr = {fml.fml_adr[mem_depth-1:5], 2'b00};
      ST_WAIT: ram_adr = {line_q, 2'b00};
      default: ram_adr = we_q ? {line_q, beat} : {line_q, beat + 2'd1};
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
      beat    <= '0;
      line_q  <= '0;
      we_q    <= 1'b0;
      do_hold <= '0;
    end else begin
      if (in_burst && !we_q) do_hold <= ram_q;
      case (state)
        ST_IDLE: begin
          beat <= '0;
          if (fml.fml_stb) begin
            line_q  <= fml.fml_adr[mem_depth-1:5];
            we_q    <= fml.fml_we;
            lat_cnt <= LAT_LOAD;
            state   <= (ack_latency == 1) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!fml.fml_stb) begin
            lat_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) state <= ST_ACK;
          end
        end
        ST_ACK: begin
          beat  <= 2'd1;
          state <= ST_BURST;
        end
        default: begin
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= ST_IDLE;
        end
      endcase
    end
  end

  fmlmem_ram #(
    .addr_w (RAM_AW)
  ) u_ram (
    .clk (sys_clk),
    .we  (ram_we),
    .sel (fml.fml_sel),
    .adr (ram_adr),
    .di  (fml.fml_di),
    .dq  (ram_q)
  );

endmodule

// File: tb/tb_fmlmem.sv
// tb_fmlmem: directed bench for fmlmem. Two instances share the bus inputs
// except the strobe: unit 0 with ack_latency = 2, unit 1 with ack_latency = 4.
module tb_fmlmem;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [25:0] adr     = '0;
  logic        we      = 1'b0;
  logic [7:0]  sel     = '0;
  logic [63:0] di      = '0;
  logic [1:0]  stb     = '0;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  fmlmem_if #(.fml_depth(26)) bus0 ();
  fmlmem_if #(.fml_depth(26)) bus1 ();

  assign bus0.fml_adr = adr;
  assign bus0.fml_we  = we;
  assign bus0.fml_sel = sel;
  assign bus0.fml_di  = di;
  assign bus0.fml_stb = stb[0];
  assign bus1.fml_adr = adr;
  assign bus1.fml_we  = we;
  assign bus1.fml_sel = sel;
  assign bus1.fml_di  = di;
  assign bus1.fml_stb = stb[1];

  fmlmem #(.fml_depth(26), .mem_depth(14), .ack_latency(2)) u_dut0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .fml     (bus0)
  );

  fmlmem #(.fml_depth(26), .mem_depth(14), .ack_latency(4)) u_dut1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .fml     (bus1)
  );

  function automatic logic get_ack(input int unsigned u);
    return (u == 0) ? bus0.fml_ack : bus1.fml_ack;
  endfunction

  function automatic logic [63:0] get_do(input int unsigned u);
    return (u == 0) ? bus0.fml_do : bus1.fml_do;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raise the strobe and wait (bounded) for ack; returns cycles to ack.
  task automatic request(input int unsigned u, input logic [25:0] a, input logic w,
                         output int n, output logic got);
    adr = a;
    we  = w;
    stb[u] = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      got = get_ack(u);
    end
    stb[u] = 1'b0;
  endtask

  task automatic wr_burst(input int unsigned u, input string tag, input logic [25:0] a,
                          input logic [3:0][7:0] s, input logic [3:0][63:0] d);
    int n;
    logic got;
    request(u, a, 1'b1, n, got);
    chk({tag, "_lat"}, 64'(n), (u == 0) ? 64'd2 : 64'd4);
    if (!got) return;
    di  = d[0];
    sel = s[0];
    for (int b = 1; b < 4; b++) begin
      tick();
      chk({tag, "_ack_low"}, 64'(get_ack(u)), 64'd0);
      di  = d[b];
      sel = s[b];
    end
    tick();
  endtask

  task automatic rd_burst(input int unsigned u, input string tag, input logic [25:0] a,
                          input logic [3:0][63:0] d);
    int n;
    logic got;
    request(u, a, 1'b0, n, got);
    chk({tag, "_lat"}, 64'(n), (u == 0) ? 64'd2 : 64'd4);
    if (!got) return;
    chk({tag, "_b0"}, get_do(u), d[0]);
    for (int b = 1; b < 4; b++) begin
      tick();
      chk({tag, "_ack_low"}, 64'(get_ack(u)), 64'd0);
      chk($sformatf("%s_b%0d", tag, b), get_do(u), d[b]);
    end
    tick();
  endtask

  initial begin : stim
    logic [3:0][63:0] d_full, d_part, d_alias, d_b, d_c, exp;
    logic [3:0][7:0]  s_all, s_part;
    int   n, first_ack, second_ack;

    d_full  = {64'h44444444_44444444, 64'h33333333_33333333,
               64'h22222222_22222222, 64'h11111111_11111111};
    d_part  = {64'hDEADDEAD_DEADDEAD, 64'hDEADDEAD_DEADDEAD,
               64'hDEADDEAD_DEADDEAD, 64'hFFFFFFFF_FFFFFFFF};
    d_alias = {64'hA3A3A3A3_A3A3A3A3, 64'hA2A2A2A2_A2A2A2A2,
               64'hA1A1A1A1_A1A1A1A1, 64'hA0A0A0A0_A0A0A0A0};
    d_b     = {64'hB3B3B3B3_00000003, 64'hB2B2B2B2_00000002,
               64'hB1B1B1B1_00000001, 64'hB0B0B0B0_00000000};
    d_c     = {64'hC3C3C3C3_C3C3C3C3, 64'hC2C2C2C2_C2C2C2C2,
               64'hC1C1C1C1_C1C1C1C1, 64'hC0C0C0C0_C0C0C0C0};
    s_all   = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    s_part  = {8'h00, 8'h00, 8'h00, 8'h0F};

    // Reset then idle
    repeat (3) tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ack", 64'(bus0.fml_ack), 64'd0);
      chk("idle_do", bus0.fml_do, 64'd0);
    end

    // Full write then read-back
    wr_burst(0, "wr_full", 26'h000040, s_all, d_full);
    rd_burst(0, "rd_full", 26'h000040, d_full);
    chk("do_hold", bus0.fml_do, 64'h44444444_44444444);

    // Partial write to beat 0 only
    wr_burst(0, "wr_part", 26'h000040, s_part, d_part);
    exp = {64'h44444444_44444444, 64'h33333333_33333333,
           64'h22222222_22222222, 64'h11111111_FFFFFFFF};
    rd_burst(0, "rd_part", 26'h000040, exp);

    // Address aliasing modulo 2^14
    wr_burst(0, "wr_alias", 26'h004040, s_all, d_alias);
    rd_burst(0, "rd_alias", 26'h000040, d_alias);

    // Latency 4 unit: baseline write/read, then aborted request
    wr_burst(1, "wr_l4", 26'h000080, s_all, d_b);
    rd_burst(1, "rd_l4", 26'h000080, d_b);
    adr = 26'h000080;
    we  = 1'b1;
    di  = 64'h0BAD0BAD_0BAD0BAD;
    sel = 8'hFF;
    stb[1] = 1'b1;
    tick();
    chk("abort_ack_a", 64'(bus1.fml_ack), 64'd0);
    tick();
    chk("abort_ack_b", 64'(bus1.fml_ack), 64'd0);
    stb[1] = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus1.fml_ack) n++;
    end
    chk("abort_no_ack", 64'(n), 64'd0);
    rd_burst(1, "rd_abort", 26'h000080, d_b);

    // Back-to-back reads with strobe held
    adr = 26'h000040;
    we  = 1'b0;
    stb[0] = 1'b1;
    first_ack  = -1;
    second_ack = -1;
    for (int i = 1; i <= 30 && second_ack < 0; i++) begin
      tick();
      if (bus0.fml_ack) begin
        if (first_ack < 0) first_ack = i;
        else second_ack = i;
      end
    end
    stb[0] = 1'b0;
    chk("b2b_first", 64'(first_ack), 64'd2);
    chk("b2b_spacing", 64'(second_ack - first_ack), 64'd6);
    repeat (4) tick();

    // Reset during beat 1 of a write burst
    sel = 8'hFF;
    request(0, 26'h000040, 1'b1, n, first_ack[0]);
    chk("rst_lat", 64'(n), 64'd2);
    di = d_c[0];
    tick();
    di = d_c[1];
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rst_ack", 64'(bus0.fml_ack), 64'd0);
    chk("rst_do", bus0.fml_do, 64'd0);
    tick();
    exp = {d_alias[3], d_alias[2], d_alias[1], d_c[0]};
    rd_burst(0, "rd_rst", 26'h000040, exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
